// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with the IF/ID pipeline register.
//
// Holds the fetch PC and issues one instruction-memory request per
// instruction. Tracks a response that is still outstanding when a redirect
// arrives (DISCARD), and holds a fetched word that ID cannot accept yet
// (WAIT_ID).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   next_pc             next-PC mux output (pc_plus4 or branch target)
//   redirect            branch/jump taken (also the next-PC mux select)
//   stall               ID hazard stall, IF/ID holds
//   flush               invalidate IF/ID
//   imem_req/imem_addr  instruction memory request and byte address
//   imem_ack/imem_rdata single-cycle memory response and data
//   pc, pc_plus4        current fetch PC and pc+4
//   ifid_instr/ifid_pc4/ifid_valid  IF/ID pipeline register
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT_ID = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] target_r;
  logic [31:0] buf_instr_r;
  logic [31:0] buf_pc4_r;
  logic [31:0] ifid_instr_r;
  logic [31:0] ifid_pc4_r;
  logic        ifid_valid_r;

  // pc_r is not advanced while a response is outstanding or buffered, so it
  // doubles as the frozen request address in DISCARD.
  assign pc         = pc_r;
  assign pc_plus4   = pc_r + 32'd4;
  assign imem_addr  = pc_r;
  // Gated by rst so a request in flight is dropped the instant reset asserts.
  assign imem_req   = ~rst & (state_r != WAIT_ID);
  assign ifid_instr = ifid_instr_r;
  assign ifid_pc4   = ifid_pc4_r;
  assign ifid_valid = ifid_valid_r;

  // Fetch FSM, PC, redirect target, holding buffer and IF/ID register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= FETCH;
      pc_r         <= RESET_PC;
      target_r     <= 32'd0;
      buf_instr_r  <= 32'd0;
      buf_pc4_r    <= 32'd0;
      ifid_instr_r <= 32'd0;
      ifid_pc4_r   <= 32'd0;
      ifid_valid_r <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          if (imem_ack) begin
            if (redirect) begin
              // Fetched word is on the wrong path: drop it.
              pc_r <= next_pc;
              if (!stall) ifid_valid_r <= 1'b0;
            end else if (!stall) begin
              ifid_instr_r <= imem_rdata;
              ifid_pc4_r   <= pc_plus4;
              ifid_valid_r <= 1'b1;
              pc_r         <= next_pc;
            end else begin
              // ID is busy: park the word until the stall clears.
              buf_instr_r <= imem_rdata;
              buf_pc4_r   <= pc_plus4;
              state_r     <= WAIT_ID;
            end
          end else begin
            // The request must complete before the target can be fetched.
            if (redirect) begin
              target_r <= next_pc;
              state_r  <= DISCARD;
            end
            if (!stall) ifid_valid_r <= 1'b0;
          end
        end
        WAIT_ID: begin
          if (redirect) begin
            pc_r    <= next_pc;
            state_r <= FETCH;
            if (!stall) ifid_valid_r <= 1'b0;
          end else if (!stall) begin
            ifid_instr_r <= buf_instr_r;
            ifid_pc4_r   <= buf_pc4_r;
            ifid_valid_r <= 1'b1;
            pc_r         <= next_pc;
            state_r      <= FETCH;
          end
        end
        DISCARD: begin
          // The most recent redirect wins, including one in the ack cycle.
          if (redirect) target_r <= next_pc;
          if (imem_ack) begin
            pc_r    <= redirect ? next_pc : target_r;
            state_r <= FETCH;
          end
          if (!stall) ifid_valid_r <= 1'b0;
        end
        default: begin
          state_r      <= FETCH;
          ifid_valid_r <= 1'b0;
        end
      endcase
      // Flush beats stall and any load in the same edge.
      if (flush) ifid_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0)
  logic        rst, redirect, stall, flush, imem_ack;
  logic [31:0] next_pc, imem_rdata;
  logic        imem_req, ifid_valid;
  logic [31:0] imem_addr, pc, pc_plus4, ifid_instr, ifid_pc4;

  // Second DUT for the wrap-around reset PC
  logic        rst2, redirect2, stall2, flush2, imem_ack2;
  logic [31:0] next_pc2, imem_rdata2;
  logic        imem_req2, ifid_valid2;
  logic [31:0] imem_addr2, pc2, pc_plus4_2, ifid_instr2, ifid_pc4_2;

  fetch_unit dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .redirect(redirect),
    .stall(stall), .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc), .pc_plus4(pc_plus4),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut2 (
    .clk(clk), .rst(rst2), .next_pc(next_pc2), .redirect(redirect2),
    .stall(stall2), .flush(flush2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .pc(pc2), .pc_plus4(pc_plus4_2),
    .ifid_instr(ifid_instr2), .ifid_pc4(ifid_pc4_2), .ifid_valid(ifid_valid2)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] tgt;
  logic [31:0] m_pc, m_tgt, m_buf_instr, m_buf_pc4, m_instr, m_pc4;
  bit          m_buf_full, m_kill, m_valid;
  // Memory model: fixed delay (>=0) or random 0..3 (<0)
  int          mem_delay, mem_cnt;
  bit          mem_busy;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input logic [31:0] p0);
    m_pc = p0; m_tgt = 32'd0; m_buf_instr = 32'd0; m_buf_pc4 = 32'd0;
    m_instr = 32'd0; m_pc4 = 32'd0;
    m_buf_full = 1'b0; m_kill = 1'b0; m_valid = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0;
  endtask

  // One clock cycle: called at a negedge, drives memory/next_pc, checks, steps model.
  task automatic cycle();
    logic        ack_v, exp_req;
    logic [31:0] npc;
    exp_req = !m_buf_full;
    npc     = redirect ? tgt : m_pc + 32'd4;
    next_pc = npc;
    ack_v   = 1'b0;
    if (exp_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
      end
      ack_v = (mem_cnt == 0);
    end
    imem_ack   = ack_v;
    imem_rdata = ack_v ? mem_word(m_pc) : 32'hDEAD_BEEF;
    #1;
    chk("imem_req",   {31'd0, imem_req},   {31'd0, exp_req});
    chk("imem_addr",  imem_addr,           m_pc);
    chk("pc",         pc,                  m_pc);
    chk("pc_plus4",   pc_plus4,            m_pc + 32'd4);
    chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pc4",   ifid_pc4,   m_pc4);
    end
    // Model step
    if (m_buf_full) begin
      if (redirect) begin
        m_buf_full = 1'b0; m_pc = npc;
        if (!stall) m_valid = 1'b0;
      end else if (!stall) begin
        m_valid = 1'b1; m_instr = m_buf_instr; m_pc4 = m_buf_pc4;
        m_pc = npc; m_buf_full = 1'b0;
      end
    end else if (m_kill) begin
      if (redirect) m_tgt = npc;
      if (ack_v) begin m_pc = m_tgt; m_kill = 1'b0; end
      if (!stall) m_valid = 1'b0;
    end else if (ack_v) begin
      if (redirect) begin
        m_pc = npc;
        if (!stall) m_valid = 1'b0;
      end else if (!stall) begin
        m_valid = 1'b1; m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_pc = npc;
      end else begin
        m_buf_full = 1'b1; m_buf_instr = mem_word(m_pc); m_buf_pc4 = m_pc + 32'd4;
      end
    end else begin
      if (redirect) begin m_kill = 1'b1; m_tgt = npc; end
      if (!stall) m_valid = 1'b0;
    end
    if (flush) m_valid = 1'b0;
    if (exp_req) begin
      if (ack_v) mem_busy = 1'b0;
      else mem_cnt--;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    bit          settled;
    rst = 1'b1; redirect = 1'b0; stall = 1'b0; flush = 1'b0; tgt = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0; next_pc = 32'd0;
    rst2 = 1'b1; redirect2 = 1'b0; stall2 = 1'b0; flush2 = 1'b0;
    imem_ack2 = 1'b0; imem_rdata2 = 32'd0; next_pc2 = 32'd0;
    mem_delay = 0;
    model_reset(32'd0);
    @(negedge clk); @(negedge clk);

    // Reset values
    chk("rst_req",    {31'd0, imem_req},   32'd0);
    chk("rst_pc",     pc,                  32'd0);
    chk("rst_pc4",    pc_plus4,            32'd4);
    chk("rst_valid",  {31'd0, ifid_valid}, 32'd0);
    chk("rst_instr",  ifid_instr,          32'd0);
    chk("rst_ifpc4",  ifid_pc4,            32'd0);
    chk("rst2_pc",    pc2,                 32'hFFFFFFFC);
    chk("rst2_pc4",   pc_plus4_2,          32'd0);
    chk("rst2_req",   {31'd0, imem_req2},  32'd0);

    // Zero-wait streaming from reset
    rst = 1'b0;
    repeat (4) cycle();
    chk("seq_pc",    pc,         32'h10);
    chk("seq_ifpc4", ifid_pc4,   32'h10);
    chk("seq_instr", ifid_instr, mem_word(32'hC));

    // Stall on ack at 0x10 for 3 cycles
    stall = 1'b1;
    repeat (3) cycle();
    stall = 1'b0;
    cycle();
    chk("stall_instr", ifid_instr,          mem_word(32'h10));
    chk("stall_ifpc4", ifid_pc4,            32'h14);
    chk("stall_valid", {31'd0, ifid_valid}, 32'd1);
    chk("stall_addr",  imem_addr,           32'h14);

    // Redirect while request at 0x20 is pending
    for (int i = 0; i < 10 && m_pc != 32'h20; i++) cycle();
    chk("reach_20", imem_addr, 32'h20);
    mem_delay = 3;
    redirect = 1'b1; tgt = 32'h100;
    cycle();
    redirect = 1'b0;
    repeat (3) cycle();
    chk("disc_addr",  imem_addr,           32'h100);
    chk("disc_valid", {31'd0, ifid_valid}, 32'd0);

    // Redirect into DISCARD, then two redirects while discarding
    redirect = 1'b1; tgt = 32'h180; cycle();
    tgt = 32'h100; cycle();
    tgt = 32'h200; cycle();
    redirect = 1'b0; cycle();
    chk("latest_tgt", imem_addr, 32'h200);

    // Flush together with stall and ack
    mem_delay = 0;
    cycle();
    stall = 1'b1; flush = 1'b1;
    cycle();
    chk("flush_valid", {31'd0, ifid_valid}, 32'd0);
    stall = 1'b0; flush = 1'b0;
    cycle();

    // Randomized traffic
    mem_delay = -1;
    repeat (300) begin
      redirect = ($urandom_range(0, 4) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      r        = $urandom;
      tgt      = {r[31:2], 2'b00};
      cycle();
    end

    // Reset asserted in the middle of DISCARD
    redirect = 1'b0; stall = 1'b0; flush = 1'b0; mem_delay = 3;
    settled = 1'b0;
    for (int i = 0; i < 20 && !settled; i++) begin
      if (!m_buf_full && !m_kill && !mem_busy) settled = 1'b1;
      else cycle();
    end
    chk("settle_bound", {31'd0, settled}, 32'd1);
    redirect = 1'b1; tgt = 32'h40;
    cycle();
    redirect = 1'b0;
    cycle();
    rst = 1'b1;
    #1;
    chk("midrst_req",   {31'd0, imem_req},   32'd0);
    chk("midrst_pc",    pc,                  32'd0);
    chk("midrst_valid", {31'd0, ifid_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset(32'd0);
    mem_delay = 0;
    repeat (3) cycle();

    // Wrap-around reset PC
    rst2 = 1'b0; imem_ack2 = 1'b1; imem_rdata2 = 32'hCAFEF00D; next_pc2 = 32'd0;
    #1;
    chk("wrap_req",   {31'd0, imem_req2}, 32'd1);
    chk("wrap_addr0", imem_addr2,         32'hFFFFFFFC);
    @(negedge clk);
    imem_ack2 = 1'b0;
    chk("wrap_addr1", imem_addr2,          32'd0);
    chk("wrap_ifpc4", ifid_pc4_2,          32'd0);
    chk("wrap_valid", {31'd0, ifid_valid2}, 32'd1);
    chk("wrap_instr", ifid_instr2,         32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
